// File: rtl/inst_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_fetch: PC owner; one-at-a-time imem reads, buffered hand-off to     |
// | decode, redirect and halt handling.                    Revision: 1.0     |
// +--------------------------------------------------------------------------+
module inst_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [INST_WIDTH-1:0] mem_rsp_data_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  halt_i,
  output logic                  halted_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic [2:0]            state_q,     state_d;
  logic [ADDR_WIDTH-1:0] pc_q,        pc_d;
  logic                  kill_q,      kill_d;
  logic                  halt_pend_q, halt_pend_d;
  logic [INST_WIDTH-1:0] inst_q,      inst_d;
  logic [ADDR_WIDTH-1:0] pc_out_q,    pc_out_d;
  logic [ADDR_WIDTH-1:0] redirect_tgt;

  // Targets are forced word-aligned.
  assign redirect_tgt = redirect_pc_i & ~ADDR_WIDTH'(3);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    halt_pend_d = halt_pend_q;
    inst_d      = inst_q;
    pc_out_d    = pc_out_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (halt_i) begin
          if (mem_req_ready_i) begin
            state_d     = S_WAIT;
            halt_pend_d = 1'b1;
          end else begin
            state_d = S_HALT;
          end
        end else begin
          if (redirect_i) pc_d = redirect_tgt;
          if (mem_req_ready_i) begin
            state_d = S_WAIT;
            kill_d  = redirect_i;
          end
        end
      end
      S_WAIT: begin
        if (halt_i) begin
          halt_pend_d = 1'b1;
        end else if (redirect_i && !halt_pend_q) begin
          pc_d   = redirect_tgt;
          kill_d = 1'b1;
        end
        // The outstanding response always drains here, kept or not.
        if (mem_rsp_valid_i) begin
          kill_d = 1'b0;
          if (halt_i || halt_pend_q) begin
            state_d = S_HALT;
          end else if (kill_q || redirect_i) begin
            state_d = S_REQ;
          end else begin
            inst_d   = mem_rsp_data_i;
            pc_out_d = pc_q;
            state_d  = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (halt_i) begin
          state_d = S_HALT;
        end else if (redirect_i) begin
          pc_d    = redirect_tgt;
          state_d = S_REQ;
        end else if (inst_ready_i) begin
          pc_d    = pc_q + ADDR_WIDTH'(4);
          state_d = S_REQ;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      inst_q      <= '0;
      pc_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      halt_pend_q <= halt_pend_d;
      inst_q      <= inst_d;
      pc_out_q    <= pc_out_d;
    end
  end

  assign mem_req_valid_o = (state_q == S_REQ);
  assign mem_req_addr_o  = pc_q;
  assign inst_valid_o    = (state_q == S_HOLD);
  assign inst_o          = inst_q;
  assign pc_o            = pc_out_q;
  assign halted_o        = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inst_fetch: directed self-checking bench for inst_fetch.              |
// |                                                        Revision: 1.0     |
// +--------------------------------------------------------------------------+
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic        halted_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i),
    .inst_o          (inst_o),
    .pc_o            (pc_o),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .halt_i          (halt_i),
    .halted_o        (halted_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".req_valid"},  {31'd0, mem_req_valid_o}, 32'd0);
    chk({tag, ".inst_valid"}, {31'd0, inst_valid_o},    32'd0);
    chk({tag, ".halted"},     {31'd0, halted_o},        32'd0);
    chk({tag, ".inst"},       inst_o,                   32'd0);
    chk({tag, ".pc"},         pc_o,                     32'd0);
  endtask

  // Starts in REQ at a negedge; zero-wait memory; ends back in REQ.
  task automatic fetch_one(input string tag, input logic [31:0] pc, input logic [31:0] word);
    chk({tag, ".req_valid"}, {31'd0, mem_req_valid_o}, 32'd1);
    chk({tag, ".req_addr"},  mem_req_addr_o, pc);
    mem_req_ready_i = 1'b1;
    cyc();
    chk({tag, ".wait_noreq"}, {31'd0, mem_req_valid_o}, 32'd0);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = word;
    cyc();
    mem_rsp_valid_i = 1'b0;
    chk({tag, ".inst_valid"}, {31'd0, inst_valid_o}, 32'd1);
    chk({tag, ".inst"},       inst_o, word);
    chk({tag, ".pc"},         pc_o,   pc);
    inst_ready_i = 1'b1;
    cyc();
    inst_ready_i = 1'b0;
  endtask

  initial begin
    rst             = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = 32'd0;
    inst_ready_i    = 1'b0;
    redirect_i      = 1'b0;
    redirect_pc_i   = 32'd0;
    halt_i          = 1'b0;

    // Reset held two cycles.
    cyc();
    chk_reset_outs("rst1");
    cyc();
    chk_reset_outs("rst2");
    rst = 1'b1;
    cyc();
    chk("rel.req_valid", {31'd0, mem_req_valid_o}, 32'd1);
    chk("rel.req_addr",  mem_req_addr_o, 32'h8000_0000);

    // Streaming, zero-wait memory.
    fetch_one("s0", 32'h8000_0000, 32'h0010_0093);
    fetch_one("s1", 32'h8000_0004, 32'h0020_0113);
    fetch_one("s2", 32'h8000_0008, 32'h0030_0193);

    // Backpressure in HOLD for 5 cycles.
    mem_req_ready_i = 1'b1;
    chk("bp.req_addr", mem_req_addr_o, 32'h8000_000C);
    cyc();
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'h0040_0213;
    cyc();
    mem_rsp_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp.inst_valid", {31'd0, inst_valid_o}, 32'd1);
      chk("bp.inst",       inst_o, 32'h0040_0213);
      chk("bp.pc",         pc_o,   32'h8000_000C);
      chk("bp.noreq",      {31'd0, mem_req_valid_o}, 32'd0);
      cyc();
    end
    inst_ready_i = 1'b1;
    cyc();
    inst_ready_i = 1'b0;
    chk("bp.next_req", {31'd0, mem_req_valid_o}, 32'd1);
    chk("bp.next_addr", mem_req_addr_o, 32'h8000_0010);

    // Redirect in WAIT, response a cycle later is dropped.
    cyc();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h8000_0103;
    cyc();
    redirect_i = 1'b0;
    chk("rw.noreq", {31'd0, mem_req_valid_o}, 32'd0);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'hDEAD_BEEF;
    cyc();
    mem_rsp_valid_i = 1'b0;
    chk("rw.inst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rw.req_valid",  {31'd0, mem_req_valid_o}, 32'd1);
    chk("rw.req_addr",   mem_req_addr_o, 32'h8000_0100);

    // Redirect together with the response in WAIT.
    cyc();
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'hBAD0_BAD0;
    redirect_i      = 1'b1;
    redirect_pc_i   = 32'h8000_0200;
    cyc();
    mem_rsp_valid_i = 1'b0;
    redirect_i      = 1'b0;
    chk("rs.inst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rs.req_addr",   mem_req_addr_o, 32'h8000_0200);
    fetch_one("rs.after", 32'h8000_0200, 32'h0050_0293);

    // Redirect in REQ while memory stalls.
    mem_req_ready_i = 1'b0;
    redirect_i      = 1'b1;
    redirect_pc_i   = 32'h8000_0300;
    cyc();
    redirect_i = 1'b0;
    chk("rq.req_valid", {31'd0, mem_req_valid_o}, 32'd1);
    chk("rq.req_addr",  mem_req_addr_o, 32'h8000_0300);

    // Redirect in HOLD with same-cycle decode handshake: target wins.
    mem_req_ready_i = 1'b1;
    cyc();
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'h0060_0313;
    cyc();
    mem_rsp_valid_i = 1'b0;
    chk("rh.inst", inst_o, 32'h0060_0313);
    inst_ready_i  = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h8000_0400;
    cyc();
    inst_ready_i = 1'b0;
    redirect_i   = 1'b0;
    chk("rh.inst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rh.req_addr",   mem_req_addr_o, 32'h8000_0400);

    // Halt in WAIT, response three cycles later.
    cyc();
    halt_i = 1'b1;
    cyc();
    halt_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("hw.halted_early", {31'd0, halted_o}, 32'd0);
      chk("hw.inst_valid",   {31'd0, inst_valid_o}, 32'd0);
      cyc();
    end
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'h0070_0393;
    cyc();
    mem_rsp_valid_i = 1'b0;
    redirect_i      = 1'b1;
    redirect_pc_i   = 32'h8000_0500;
    for (int i = 0; i < 3; i++) begin
      chk("hw.halted",     {31'd0, halted_o}, 32'd1);
      chk("hw.inst_valid", {31'd0, inst_valid_o}, 32'd0);
      chk("hw.noreq",      {31'd0, mem_req_valid_o}, 32'd0);
      cyc();
      redirect_i = 1'b0;
    end

    // Reset out of HALT, then reset again mid-WAIT with a late response.
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    chk("r6.req_addr", mem_req_addr_o, 32'h8000_0000);
    cyc();
    rst = 1'b0;
    cyc();
    chk("r6.rst_req",     {31'd0, mem_req_valid_o}, 32'd0);
    chk("r6.rst_halted",  {31'd0, halted_o}, 32'd0);
    chk("r6.rst_inst",    inst_o, 32'd0);
    rst             = 1'b1;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'hFFFF_FFFF;
    mem_req_ready_i = 1'b0;
    cyc();
    chk("r6.late_iv", {31'd0, inst_valid_o}, 32'd0);
    chk("r6.restart", mem_req_addr_o, 32'h8000_0000);
    cyc();
    mem_rsp_valid_i = 1'b0;
    chk("r6.late_iv2", {31'd0, inst_valid_o}, 32'd0);
    fetch_one("r6.fetch", 32'h8000_0000, 32'h0080_0413);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
